// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encodings and winner codes.
package pong_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SERVE = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
    localparam logic [STATE_W-1:0] ST_POINT = 3'd3;
    localparam logic [STATE_W-1:0] ST_OVER  = 3'd4;
    localparam logic [STATE_W-1:0] ST_PAUSE = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_edge_det.sv
// Two-channel rising-edge detector; a level held high yields a single-clk pulse.
module pong_edge_det (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] rise
);

    logic [1:0] prev_q;
    logic [1:0] prev_d;

    always_comb begin
        prev_d = din;
        rise   = din & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: scores, serve/play/point/game-over flow, round reset and play enable.
// Optional PAUSE state is built when PONG_PAUSE_EN is defined.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic       round_rst,
    output logic       play_en,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam logic [7:0] SERVE_LIM = 8'(SERVE_TICKS);
    localparam logic [7:0] POINT_LIM = 8'(POINT_TICKS);
    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         tick_cnt_q, tick_cnt_d;
    logic [3:0]         score_1_q, score_1_d;
    logic [3:0]         score_2_q, score_2_d;
    logic [1:0]         winner_q, winner_d;
    logic [7:0]         tick_inc;
    logic [1:0]         rise;

`ifndef PONG_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    pong_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  ({point_p2, point_p1}),
        .rise (rise)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        score_1_d  = score_1_q;
        score_2_d  = score_2_q;
        winner_d   = winner_q;
        tick_inc   = tick_cnt_q + 8'd1;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d    = ST_SERVE;
                    tick_cnt_d = '0;
                    score_1_d  = '0;
                    score_2_d  = '0;
                    winner_d   = WIN_NONE;
                end
            end
            ST_SERVE: begin
                if (game_tick) begin
                    if (tick_inc == SERVE_LIM) begin
                        state_d    = ST_PLAY;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
            end
            ST_PLAY: begin
                // A coincident pair of edges is a replay; a point outranks pause.
                if (rise[0] && rise[1]) begin
                    state_d    = ST_POINT;
                    tick_cnt_d = '0;
                end else if (rise[0]) begin
                    state_d    = ST_POINT;
                    tick_cnt_d = '0;
                    score_1_d  = score_1_q + 4'd1;
                end else if (rise[1]) begin
                    state_d    = ST_POINT;
                    tick_cnt_d = '0;
                    score_2_d  = score_2_q + 4'd1;
                end
`ifdef PONG_PAUSE_EN
                else if (pause) begin
                    state_d    = ST_PAUSE;
                    tick_cnt_d = '0;
                end
`endif
            end
            ST_POINT: begin
                if (game_tick) begin
                    if (tick_inc == POINT_LIM) begin
                        tick_cnt_d = '0;
                        if (score_1_q == WIN_LIM) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_P1;
                        end else if (score_2_q == WIN_LIM) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_P2;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (pause) begin
                    state_d    = ST_PLAY;
                    tick_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            score_1_q  <= '0;
            score_2_q  <= '0;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            score_1_q  <= score_1_d;
            score_2_q  <= score_2_d;
            winner_q   <= winner_d;
        end
    end

    // PAUSE freezes the field without resetting it, so round_rst stays low there.
    assign round_rst = !((state_q == ST_PLAY) || (state_q == ST_PAUSE));
    assign play_en   = (state_q == ST_PLAY);
    assign score_1   = score_1_q;
    assign score_2   = score_2_q;
    assign winner    = winner_q;
    assign state_o   = state_q;

endmodule
